// File: rtl/ascii_num_stream_sep_if.sv
// ---------------------------------------------------------------------------
// ascii_num_stream_sep_if
// Purpose : bundles the byte-stream handshake from the UART packet deframer
//           and the number-RAM write port of ascii_num_stream_sep.
// Signals : pkt_payload_data/valid/last  byte stream into the separator
//           pkt_payload_ready            byte accepted when valid && ready
//           ram_wr_en/addr/data          one-cycle write of a parsed value
// Modports: master - byte source / RAM side (drives payload, observes writes)
//           slave  - the separator itself
// ---------------------------------------------------------------------------
interface ascii_num_stream_sep_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic [7:0]            pkt_payload_data;
  logic                  pkt_payload_valid;
  logic                  pkt_payload_last;
  logic                  pkt_payload_ready;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;

  modport master (
    output pkt_payload_data, pkt_payload_valid, pkt_payload_last,
    input  pkt_payload_ready,
    input  ram_wr_en, ram_wr_addr, ram_wr_data
  );

  modport slave (
    input  pkt_payload_data, pkt_payload_valid, pkt_payload_last,
    output pkt_payload_ready,
    output ram_wr_en, ram_wr_addr, ram_wr_data
  );
endinterface

// File: rtl/ascii_num_stream_sep.sv
// ---------------------------------------------------------------------------
// ascii_num_stream_sep
// Purpose : parses a packet payload of decimal ASCII integers on the fly, one
//           byte per cycle, and writes each value to a number RAM at
//           consecutive addresses starting at 0.
// Ports   : clk, rst (async, active-high), clear (sync, wins over everything)
//           bus        payload stream in / RAM write port out (slave modport)
//           busy       packet in progress
//           done       sticky: packet parsed, num_count final
//           invalid    sticky: packet rejected
//           ovf        sticky: at least one value saturated (SAT_EN=1 only)
//           num_count  numbers written so far
// ---------------------------------------------------------------------------
module ascii_num_stream_sep #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_NUMS   = 2048,
  parameter bit SAT_EN     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  ascii_num_stream_sep_if.slave bus,
  output logic                  busy,
  output logic                  done,
  output logic                  invalid,
  output logic                  ovf,
  output logic [ADDR_WIDTH:0]   num_count
);

  localparam int CW = ADDR_WIDTH + 1;   // counter width
  localparam int MW = DATA_WIDTH + 1;   // magnitude accumulator width
  localparam int EW = DATA_WIDTH + 5;   // wide enough for acc*10+9 without wrap

  localparam logic [MW-1:0] NEG_LIM = {2'b01, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [MW-1:0] POS_LIM = NEG_LIM - MW'(1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_NUMS);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_SIGN, S_DIGIT, S_DRAIN, S_FIN, S_DONE, S_ERR
  } state_e;

  state_e                state_q,   state_d;
  logic [MW-1:0]         acc_q,     acc_d;
  logic                  neg_q,     neg_d;
  logic                  sat_q,     sat_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q,    done_d;
  logic                  invalid_q, invalid_d;
  logic                  ovf_q,     ovf_d;
  logic [CW-1:0]         count_q,   count_d;

  // Character classes of the byte currently offered.
  logic [7:0] ch;
  logic       is_digit, is_minus, is_sep, last;
  assign ch       = bus.pkt_payload_data;
  assign last     = bus.pkt_payload_last;
  assign is_digit = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_minus = (ch == 8'h2D);
  assign is_sep   = (ch == 8'h20) || (ch == 8'h2C) || (ch == 8'h09) ||
                    (ch == 8'h0D) || (ch == 8'h0A);

  logic in_gap, stall, ready, accept;
  assign in_gap = (state_q == S_IDLE) || (state_q == S_GAP);
  // A last-byte digit right after a separator emit would emit again next
  // cycle; hold it off for the one cycle the previous write is on the port.
  assign stall  = wr_en_q && in_gap && bus.pkt_payload_valid && is_digit && last;
  assign ready  = !(state_q inside {S_FIN, S_DONE, S_ERR}) && !stall;
  assign accept = bus.pkt_payload_valid && ready;

  // One decimal step on the magnitude; a digit seen from IDLE/GAP starts a
  // fresh positive number. The sign is known before the first digit, so the
  // clamp limit is fixed for the whole number.
  logic          neg_eff, over, sat_new;
  logic [MW-1:0] base, lim, acc_new;
  logic [EW-1:0] step;
  assign neg_eff = in_gap ? 1'b0 : neg_q;
  assign base    = (state_q == S_DIGIT) ? acc_q : '0;
  assign step    = EW'(base) * EW'(10) + EW'(ch[3:0]);
  assign lim     = neg_eff ? NEG_LIM : POS_LIM;
  assign over    = step > EW'(lim);
  assign acc_new = over ? lim : step[MW-1:0];
  assign sat_new = ((state_q == S_DIGIT) && sat_q) || over;

  logic                  err, emit, emit_neg, emit_sat;
  logic [DATA_WIDTH-1:0] emit_mag;

  // NOTE: every signal written here gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    sat_d     = sat_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = done_q;
    invalid_d = invalid_q;
    ovf_d     = ovf_q;
    count_d   = count_q;
    err       = 1'b0;
    emit      = 1'b0;
    emit_mag  = acc_q[DATA_WIDTH-1:0];
    emit_neg  = neg_q;
    emit_sat  = sat_q;

    if (accept) begin
      case (state_q)
        S_IDLE, S_GAP, S_SIGN, S_DIGIT: begin
          if (is_digit) begin
            if (in_gap && (count_q == MAX_CNT)) begin
              err = 1'b1;
            end else if (over && !SAT_EN) begin
              err = 1'b1;
            end else begin
              acc_d = acc_new;
              neg_d = neg_eff;
              sat_d = sat_new;
              if (last) begin
                emit     = 1'b1;
                emit_mag = acc_new[DATA_WIDTH-1:0];
                emit_neg = neg_eff;
                emit_sat = sat_new;
                state_d  = S_FIN;
              end else begin
                state_d  = S_DIGIT;
              end
            end
          end else if (is_minus && in_gap) begin
            // A trailing '-' can never become a number.
            if ((count_q == MAX_CNT) || last) begin
              err = 1'b1;
            end else begin
              neg_d   = 1'b1;
              state_d = S_SIGN;
            end
          end else if (is_sep && (state_q != S_SIGN)) begin
            if (state_q == S_DIGIT) begin
              emit    = 1'b1;
              state_d = last ? S_FIN : S_GAP;
            end else if (last) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_GAP;
            end
          end else begin
            err = 1'b1;
          end
        end
        S_DRAIN: begin
          if (last) begin
            state_d   = S_ERR;
            invalid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    // The final write is on the port this cycle; done follows it.
    if (state_q == S_FIN) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end

    if (err) begin
      if (last) begin
        state_d   = S_ERR;
        invalid_d = 1'b1;
      end else begin
        state_d   = S_DRAIN;
      end
    end

    if (emit) begin
      wr_en_d   = 1'b1;
      wr_addr_d = count_q[ADDR_WIDTH-1:0];
      wr_data_d = emit_neg ? (~emit_mag + DATA_WIDTH'(1)) : emit_mag;
      count_d   = count_q + CW'(1);
      if (emit_sat) ovf_d = 1'b1;
    end

    if (clear) begin
      state_d   = S_IDLE;
      acc_d     = '0;
      neg_d     = 1'b0;
      sat_d     = 1'b0;
      wr_en_d   = 1'b0;
      wr_addr_d = '0;
      wr_data_d = '0;
      done_d    = 1'b0;
      invalid_d = 1'b0;
      ovf_d     = 1'b0;
      count_d   = '0;
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      sat_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      invalid_q <= 1'b0;
      ovf_q     <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      sat_q     <= sat_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      invalid_q <= invalid_d;
      ovf_q     <= ovf_d;
      count_q   <= count_d;
    end
  end

  assign bus.pkt_payload_ready = ready;
  assign bus.ram_wr_en         = wr_en_q;
  assign bus.ram_wr_addr       = wr_addr_q;
  assign bus.ram_wr_data       = wr_data_q;
  assign busy                  = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign done                  = done_q;
  assign invalid               = invalid_q;
  assign ovf                   = ovf_q;
  assign num_count             = count_q;

endmodule

// File: tb/tb_ascii_num_stream_sep.sv
// ---------------------------------------------------------------------------
// tb_ascii_num_stream_sep
// Three instances share clk/rst/clear and one byte driver:
//   u0: SAT_EN=0, MAX_NUMS=2048   u1: SAT_EN=1, MAX_NUMS=2048
//   u2: SAT_EN=0, MAX_NUMS=4, ADDR_WIDTH=2 (full address space, no wrap)
// Expected writes and flags come from a token-level reference model.
// ---------------------------------------------------------------------------
module tb_ascii_num_stream_sep;

  logic clk = 1'b0;
  logic rst, clear;
  logic [7:0] drv_data;
  logic drv_valid, drv_last;
  int   sel;

  always #5 clk = ~clk;

  ascii_num_stream_sep_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) if0 ();
  ascii_num_stream_sep_if #(.DATA_WIDTH(32), .ADDR_WIDTH(11)) if1 ();
  ascii_num_stream_sep_if #(.DATA_WIDTH(32), .ADDR_WIDTH(2))  if2 ();

  assign if0.pkt_payload_data  = drv_data;
  assign if1.pkt_payload_data  = drv_data;
  assign if2.pkt_payload_data  = drv_data;
  assign if0.pkt_payload_last  = drv_last;
  assign if1.pkt_payload_last  = drv_last;
  assign if2.pkt_payload_last  = drv_last;
  assign if0.pkt_payload_valid = drv_valid && (sel == 0);
  assign if1.pkt_payload_valid = drv_valid && (sel == 1);
  assign if2.pkt_payload_valid = drv_valid && (sel == 2);

  logic [2:0]  busy_v, done_v, inv_v, ovf_v, rdy_v;
  logic [11:0] cnt0, cnt1;
  logic [2:0]  cnt2;
  assign rdy_v = {if2.pkt_payload_ready, if1.pkt_payload_ready, if0.pkt_payload_ready};

  ascii_num_stream_sep #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MAX_NUMS(2048), .SAT_EN(1'b0)) u0 (
    .clk(clk), .rst(rst), .clear(clear), .bus(if0), .busy(busy_v[0]), .done(done_v[0]),
    .invalid(inv_v[0]), .ovf(ovf_v[0]), .num_count(cnt0));
  ascii_num_stream_sep #(.DATA_WIDTH(32), .ADDR_WIDTH(11), .MAX_NUMS(2048), .SAT_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .clear(clear), .bus(if1), .busy(busy_v[1]), .done(done_v[1]),
    .invalid(inv_v[1]), .ovf(ovf_v[1]), .num_count(cnt1));
  ascii_num_stream_sep #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .MAX_NUMS(4), .SAT_EN(1'b0)) u2 (
    .clk(clk), .rst(rst), .clear(clear), .bus(if2), .busy(busy_v[2]), .done(done_v[2]),
    .invalid(inv_v[2]), .ovf(ovf_v[2]), .num_count(cnt2));

  // ---------------- write monitor ----------------
  typedef struct {
    int          dut;
    int          addr;
    logic [31:0] data;
  } wr_t;
  wr_t got[$];

  always @(negedge clk) if (if0.ram_wr_en) got.push_back('{0, int'(if0.ram_wr_addr), if0.ram_wr_data});
  always @(negedge clk) if (if1.ram_wr_en) got.push_back('{1, int'(if1.ram_wr_addr), if1.ram_wr_data});
  always @(negedge clk) if (if2.ram_wr_en) got.push_back('{2, int'(if2.ram_wr_addr), if2.ram_wr_data});

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic int cnt_of(input int k);
    case (k)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt2);
    endcase
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] exp_wr[$];
  bit exp_done, exp_inv, exp_ovf, exp_late;
  int exp_cnt;

  function automatic bit is_dig(input byte c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic bit is_sp(input byte c);
    return (c == 8'h20) || (c == 8'h2C) || (c == 8'h09) || (c == 8'h0D) || (c == 8'h0A);
  endfunction

  function automatic string chr(input byte c);
    string t;
    t = " ";
    t.putc(0, c);
    return t;
  endfunction

  // Splits the payload into separator-delimited tokens; each token must be
  // -?[0-9]+ and is evaluated with plain integer arithmetic. The first bad
  // token ends the packet as invalid; earlier values stay written.
  task automatic model_pkt(input string s, input bit sat, input int max_n);
    string tok;
    bit    bad;
    byte   lc, pc;
    exp_wr.delete();
    exp_ovf = 0;
    bad     = 0;
    tok     = "";
    for (int i = 0; i <= s.len() && !bad; i++) begin
      byte c;
      c = (i < s.len()) ? s[i] : 8'h20;
      if (!is_sp(c)) begin
        tok = {tok, chr(c)};
      end else if (tok.len() > 0) begin
        if (exp_wr.size() == max_n) begin
          bad = 1;
        end else begin
          bit     neg, o;
          int     st;
          longint mag, lim;
          neg = (tok[0] == 8'h2D);
          st  = neg ? 1 : 0;
          mag = 0;
          o   = 0;
          lim = neg ? 64'd2147483648 : 64'd2147483647;
          if (tok.len() == st) bad = 1;
          for (int j = st; j < tok.len() && !bad; j++) begin
            if (!is_dig(tok[j])) begin
              bad = 1;
            end else begin
              mag = mag * 10 + longint'(tok[j] - 8'h30);
              if (mag > lim) begin
                if (sat) begin mag = lim; o = 1; end
                else bad = 1;
              end
            end
          end
          if (!bad) begin
            exp_wr.push_back(neg ? 32'(-mag) : 32'(mag));
            if (o) exp_ovf = 1;
          end
        end
        tok = "";
      end
    end
    exp_inv  = bad;
    exp_done = !bad;
    exp_cnt  = exp_wr.size();
    lc = s[s.len()-1];
    pc = (s.len() > 1) ? s[s.len()-2] : 8'h20;
    // The packet's last byte finishes a number: write first, done a cycle later.
    exp_late = !bad && (is_dig(lc) || (is_sp(lc) && is_dig(pc)));
  endtask

  // ---------------- stimulus ----------------
  task automatic do_clear(input int k);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    got.delete();
    check("clr_flags", {60'd0, busy_v[k], done_v[k], inv_v[k], ovf_v[k]}, 64'd0);
    check("clr_cnt", 64'(cnt_of(k)), 64'd0);
    check("clr_ready", 64'(rdy_v[k]), 64'd1);
  endtask

  // Returns just after the posedge that accepts the final byte.
  task automatic send_bytes(input int k, input string s, input bit with_last);
    sel = k;
    for (int i = 0; i < s.len(); i++) begin
      int gap;
      bit r;
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        drv_valid = 1'b0;
      end
      @(negedge clk);
      drv_data  = s[i];
      drv_valid = 1'b1;
      drv_last  = with_last && (i == s.len() - 1);
      r = 1'b0;
      for (int w = 0; w < 10; w++) begin
        #1 r = rdy_v[k];
        @(posedge clk);
        if (r) break;
        @(negedge clk);
      end
      if (!r) begin
        check("ready_wait", 64'(r), 64'd1);
        return;
      end
    end
  endtask

  task automatic run_pkt(input int k, input string s);
    model_pkt(s, k == 1, (k == 2) ? 4 : 2048);
    do_clear(k);
    send_bytes(k, s, 1'b1);
    @(negedge clk);
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    check("done_lat1", 64'(done_v[k]), 64'(exp_done && !exp_late));
    check("inv_lat1", 64'(inv_v[k]), 64'(exp_inv));
    @(negedge clk);
    check("done", 64'(done_v[k]), 64'(exp_done));
    check("invalid", 64'(inv_v[k]), 64'(exp_inv));
    check("ovf", 64'(ovf_v[k]), 64'(exp_ovf));
    check("num_count", 64'(cnt_of(k)), 64'(exp_cnt));
    check("busy_end", 64'(busy_v[k]), 64'd0);
    check("ready_end", 64'(rdy_v[k]), 64'd0);
    check("wr_count", 64'(got.size()), 64'(exp_wr.size()));
    foreach (exp_wr[i]) begin
      if (i < got.size()) begin
        check("wr_dut", 64'(got[i].dut), 64'(k));
        check("wr_addr", 64'(got[i].addr), 64'(i));
        check("wr_data", 64'(got[i].data), 64'(exp_wr[i]));
      end
    end
  endtask

  function automatic byte sep_char();
    case ($urandom_range(0, 4))
      0:       return 8'h20;
      1:       return 8'h2C;
      2:       return 8'h09;
      3:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  function automatic string rand_pkt();
    string s;
    int    ntok;
    s    = "";
    ntok = $urandom_range(0, 6);
    for (int t = 0; t < ntok; t++) begin
      int nsep, kind, nd;
      nsep = (t == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(1, 2));
      for (int j = 0; j < nsep; j++) s = {s, chr(sep_char())};
      kind = $urandom_range(0, 19);
      if (kind == 0) begin
        s = {s, chr(byte'(8'h30 + $urandom_range(0, 9))), "x"};
      end else if (kind == 1) begin
        s = {s, "-"};
      end else begin
        if ($urandom_range(0, 2) == 0) s = {s, "-"};
        nd = (kind == 2) ? int'($urandom_range(10, 12)) : int'($urandom_range(1, 9));
        for (int j = 0; j < nd; j++) s = {s, chr(byte'(8'h30 + $urandom_range(0, 9)))};
      end
    end
    if ($urandom_range(0, 1) == 1) s = {s, chr(sep_char())};
    if (s.len() == 0) s = " ";
    return s;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    drv_data  = 8'h00;
    drv_valid = 1'b0;
    drv_last  = 1'b0;
    sel       = 0;
    repeat (3) @(negedge clk);
    check("rst_flags", {52'd0, busy_v, done_v, inv_v, ovf_v}, 64'd0);
    check("rst_cnt", 64'(cnt_of(0) + cnt_of(1) + cnt_of(2)), 64'd0);
    check("rst_ready", 64'(rdy_v), 64'd7);
    rst = 1'b0;
    @(negedge clk);
    check("rst_wr_en", {61'd0, if2.ram_wr_en, if1.ram_wr_en, if0.ram_wr_en}, 64'd0);

    run_pkt(0, "12 -7,0\n");
    if (got.size() == 3) begin
      check("t1_w0", 64'(got[0].data), 64'd12);
      check("t1_w1", 64'(got[1].data), 64'hFFFF_FFF9);
      check("t1_w2", 64'(got[2].data), 64'd0);
    end
    run_pkt(0, "2147483647 -2147483648");
    if (got.size() == 2) begin
      check("t2_w0", 64'(got[0].data), 64'h7FFF_FFFF);
      check("t2_w1", 64'(got[1].data), 64'h8000_0000);
    end
    run_pkt(1, "99999999999");
    check("t3_ovf", 64'(ovf_v[1]), 64'd1);
    run_pkt(0, "99999999999");
    check("t4_inv", 64'(inv_v[0]), 64'd1);
    run_pkt(0, "1 2x 3");
    run_pkt(2, "1 2 3 4 5");
    check("t6_cnt", 64'(cnt2), 64'd4);
    run_pkt(2, "- 3");
    run_pkt(2, "1 2 3 4");
    run_pkt(0, " ,\t\r");
    run_pkt(1, "-0 007 -99999999999,");
    run_pkt(0, "5 6");
    run_pkt(0, "-");
    run_pkt(1, "3 --4");

    for (int n = 0; n < 40; n++) run_pkt(int'($urandom_range(0, 2)), rand_pkt());

    // Reset in the middle of a packet, while a write is on the port.
    do_clear(0);
    send_bytes(0, "12 34 ", 1'b0);
    #2 rst = 1'b1;
    got.delete();
    #1;
    check("mid_rst_wr_en", 64'(if0.ram_wr_en), 64'd0);
    check("mid_rst_flags", {60'd0, busy_v[0], done_v[0], inv_v[0], ovf_v[0]}, 64'd0);
    check("mid_rst_cnt", 64'(cnt0), 64'd0);
    @(negedge clk);
    drv_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_no_wr", 64'(got.size()), 64'd0);
    check("mid_rst_ready", 64'(rdy_v[0]), 64'd1);
    check("mid_rst_busy", 64'(busy_v[0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
